// File: rtl/systolic_skew_feeder.sv
// Input staging for the NxN systolic array: buffers one X/W tile, then replays it with diagonal skew.
// Optional macro SKEW_FEEDER_DBUF_EN adds a second (ping/pong) tile buffer so loading overlaps issue.
package systolic_array_pkg;
    typedef logic [15:0] word_t;
endpackage

module systolic_skew_feeder
    import systolic_array_pkg::*;
#(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    output logic          load_ready,
    input  word_t [N-1:0] load_x,
    input  word_t [N-1:0] load_w,
    input  logic          arr_stall,
    output word_t [N-1:0] x_in,
    output word_t [N-1:0] w_in,
    output logic          start,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state_dbg
);
    localparam int CW = $clog2(N);
    localparam int TW = $clog2(2 * N);
    localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] wr_cnt;
    logic [TW-1:0] t_q, t_sel;
    logic          load_fire, tile_last, issue_adv, issue_end;
    word_t [N-1:0] x_nxt, w_nxt;
    logic          wr_sel, rd_sel;

`ifdef SKEW_FEEDER_DBUF_EN
    localparam int NB = 2;
    logic [1:0] full;
`else
    localparam int NB = 1;
    assign wr_sel = 1'b0;
    assign rd_sel = 1'b0;
`endif

    word_t x_buf [NB][N][N];
    word_t w_buf [NB][N][N];

    // A beat transfers on any rising edge where load_valid && load_ready; load_valid
    // is ignored while load_ready is low and the beat contents are never written.
    assign load_fire = load_valid && load_ready;
    assign tile_last = load_fire && (wr_cnt == CW'(N - 1));
    assign issue_adv = (state == ISSUE) && !arr_stall;
    assign issue_end = issue_adv && (t_q == T_LAST);

`ifdef SKEW_FEEDER_DBUF_EN
    assign load_ready = !rst && !full[wr_sel];
`else
    assign load_ready = !rst && ((state == IDLE) || (state == LOAD));
`endif

    assign start     = issue_adv;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    // Beat k carries X row k and W column k; W is stored row-major so reads mirror X.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            for (int k = 0; k < N; k++) begin
                x_buf[wr_sel][wr_cnt][CW'(k)] <= load_x[k];
                w_buf[wr_sel][CW'(k)][wr_cnt] <= load_w[k];
            end
        end
    end

    // Skewed slice for the next issue step: lane i carries element (t - i) of its row/column.
    always_comb begin
        int d;
        d     = 0;
        t_sel = (state == ISSUE) ? t_q + 1'b1 : '0;
        x_nxt = '0;
        w_nxt = '0;
        for (int i = 0; i < N; i++) begin
            d = int'(t_sel) - i;
            if (d >= 0 && d < N) begin
                x_nxt[i] = x_buf[rd_sel][CW'(i)][CW'(d)];
                w_nxt[i] = w_buf[rd_sel][CW'(d)][CW'(i)];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (load_fire) state_nxt = LOAD;
            LOAD:  if (tile_last) state_nxt = ISSUE;
            ISSUE: if (issue_end) state_nxt = DONE;
            DONE: begin
`ifdef SKEW_FEEDER_DBUF_EN
                // rd_sel already points at the pending buffer here.
                if (full[rd_sel] || tile_last)
                    state_nxt = ISSUE;
                else if (wr_cnt != '0 || load_fire)
                    state_nxt = LOAD;
                else
                    state_nxt = IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_cnt <= '0;
            t_q    <= '0;
            x_in   <= '0;
            w_in   <= '0;
        end else begin
            state <= state_nxt;
            if (load_fire)
                wr_cnt <= wr_cnt + 1'b1;
            if (state != ISSUE && state_nxt == ISSUE) begin
                t_q  <= '0;
                x_in <= x_nxt;
                w_in <= w_nxt;
            end else if (issue_end) begin
                t_q  <= '0;
                x_in <= '0;
                w_in <= '0;
            end else if (issue_adv) begin
                t_q  <= t_q + 1'b1;
                x_in <= x_nxt;
                w_in <= w_nxt;
            end
        end
    end

`ifdef SKEW_FEEDER_DBUF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (tile_last) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= ~wr_sel;
            end
            if (issue_end) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
            end
        end
    end
`endif

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Input staging stage directly upstream of the N×N systolic array. Accepts one X row and one W column per beat until a full N×N tile of each is buffered. Then replays the tile onto the array's `x_in`/`w_in` edge ports with the diagonal skew the array requires, raising `start` on each issue cycle. Honours the array's `stall` output and pulses `done` when a tile has been fully issued.

## Interface
Parameters:
- `N`, default 4: array dimension; tile is N×N; N ≥ 2, power of two.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `load_valid`  in  1  `load_x`/`load_w` hold a valid beat
- `load_ready`  out  1  feeder can accept a beat
- `load_x`  in  word_t[N-1:0]  row r of X (element k = X[r][k])
- `load_w`  in  word_t[N-1:0]  column c of W (element k = W[k][c])
- `arr_stall`  in  1  array's `stall` output
- `x_in`  out  word_t[N-1:0]  to array `x_in`
- `w_in`  out  word_t[N-1:0]  to array `w_in`
- `start`  out  1  to array `start`
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse after the last issue cycle of a tile

`word_t` comes from `systolic_array_pkg`.

## Operation
- States:
  - IDLE: `load_ready`=1. An accepted beat writes slot 0 → LOAD.
  - LOAD: `load_ready`=1. Beat k (0..N-1) writes X row k and W column k. After beat N-1 is accepted → ISSUE on the next edge.
  - ISSUE: `load_ready`=0 (see Configuration). Counter t runs 0..2N-2. After t=2N-2 completes → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Beat accept rule: `load_valid && load_ready`.
- Load counter: $clog2(N) bits; resets to 0 on entering IDLE.
- Issue outputs, registered:
  - x_in[i] = X[i][t-i] when 0 ≤ t-i < N, else 0.
  - w_in[j] = W[t-j][j] when 0 ≤ t-j < N, else 0.
- `start`=1 on every ISSUE cycle where `arr_stall`=0.
- Stall: while `arr_stall`=1 in ISSUE, t holds, `x_in`/`w_in` hold their values, and `start`=0. Issue resumes at the same t when stall drops.
- Word values pass through untouched; no arithmetic on data.

## Timing
- Reset values: `load_ready`=0 during the reset cycle, then 1 (IDLE); `x_in`=`w_in`=0; `start`=0; `busy`=0; `done`=0; t=0; load counter=0. Buffer contents are not cleared.
- Reset mid-LOAD or mid-ISSUE: return to IDLE on the next edge, partial tile discarded, no `done`.
- Load latency: the tile is complete on the edge accepting beat N-1. The first ISSUE output (t=0) is visible one cycle later.
- Issue length: 2N-1 unstalled cycles. `done` asserts the cycle after t=2N-2. `busy` falls the cycle after `done`.
- `arr_stall` sampled in IDLE, LOAD, or DONE: no effect.
- `load_valid` high while `load_ready`=0: ignored, no data written.

## Configuration
- `SKEW_FEEDER_DBUF_EN` defined:
  - Two tile buffers (ping/pong). `load_ready` stays 1 during ISSUE while the other buffer is not full.
  - A full pending buffer causes DONE → ISSUE directly (skipping IDLE), with `done` still pulsing for one cycle.
  - `load_ready`=0 when both buffers are full.
- Undefined: a single buffer; `load_ready`=0 in ISSUE and DONE.

## Test plan
- Reset then load X=[[1..4],[5..8],[9..12],[13..16]], W=identity, N=4 → x_in[0] sequence 1,2,3,4,0,0,0; x_in[3] sequence 0,0,0,13,14,15,16; `start` high for 7 cycles; `done` pulse at cycle 8 after the first issue.
- Same tile with `arr_stall`=1 at t=3 for 2 cycles → x_in/w_in frozen at t=3 values, `start`=0 for 2 cycles, total issue length 9 cycles.
- `load_valid` toggling 1,0,1,0… → exactly 4 beats accepted; ISSUE begins the cycle after the 4th accept.
- Assert `rst` at t=2 of ISSUE → next cycle `busy`=0, `x_in`=0, `load_ready`=1, no `done`.
- With `SKEW_FEEDER_DBUF_EN`: load a second tile during the first issue → `done` pulse, then the second tile's t=0 outputs on the following cycle with no IDLE gap.
- Without the macro: `load_valid`=1 during ISSUE → `load_ready`=0 and buffer unchanged, verified by identical issue of the next tile.
